spi_rx_framed: RTL and testbench



---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_rx_fifo.sv | 51 +++++
 rtl/spi_rx_framed.sv | 163 ++++++++++++++++
 tb/tb_spi_rx_framed.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI receive path: mode encoding, FSM states and the
// tagged word carried through the output FIFO.
package spi_pkg;

  // Widest word rx_word_t can carry; narrower receivers zero-extend into it.
  localparam int unsigned MaxDataWidth = 32;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  typedef enum logic {
    StIdle,
    StRecv
  } rx_state_e;

  typedef struct packed {
    logic [MaxDataWidth-1:0] data;
    logic                    first;
    logic                    last;
  } rx_word_t;

  function automatic logic sample_on_rising(spi_mode_t mode);
    return (mode == MODE0) || (mode == MODE3);
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Show-ahead synchronous FIFO of rx_word_t; the head entry is visible on
// rd_data_o whenever rd_valid_o is high.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_valid_i,
  input  rx_word_t               wr_data_i,
  output logic                   full_o,
  output rx_word_t               rd_data_o,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  rx_word_t        mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            wr_en, rd_en;

  assign rd_valid_o = (count_q != '0);
  assign full_o     = (count_q == FullCount);
  assign rd_en      = rd_valid_o & rd_ready_i;
  // A full FIFO still accepts a write when the head leaves on the same cycle.
  assign wr_en      = wr_valid_i & (~full_o | rd_en);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + {{PtrW{1'b0}}, wr_en} - {{PtrW{1'b0}}, rd_en};
    end
  end

endmodule

// File: rtl/spi_rx_framed.sv
// SPI slave receiver: synchronises the pads, deserialises words in any SPI mode,
// tags first/last word of each chip-select frame and queues them in a FIFO.
module spi_rx_framed
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          data_in,
  input  logic                          data_clk_in,
  input  logic                          sel_in,
  input  logic [1:0]                    mode_in,
  input  logic                          err_clr_in,
  output logic [DATA_WIDTH-1:0]         m_data_out,
  output logic                          m_first_out,
  output logic                          m_last_out,
  output logic                          m_valid_out,
  input  logic                          m_ready_in,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          overrun_out,
  output logic                          short_frame_out
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  logic [SYNC_STAGES-1:0] sel_sync_q, sclk_sync_q, data_sync_q, sync_fill_q;
  logic                   sel_s, sclk_s, data_s, sync_ok, sclk_prev_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sel_sync_q  <= '1;
      sclk_sync_q <= '0;
      data_sync_q <= '0;
      sync_fill_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], sel_in};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], data_clk_in};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data_in};
      sync_fill_q <= {sync_fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sel_s  = sel_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  // The reset value of the sel chain must not arm the receiver; only real samples may.
  assign sync_ok = sync_fill_q[SYNC_STAGES-1];

  rx_state_e             state_q;
  spi_mode_t             mode_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q, hold_q, shift_next;
  logic                  hold_valid_q, hold_first_q, first_pending_q, armed_q;
  logic                  in_recv, edge_seen, sample, word_done, sel_rise;
  logic                  push_valid, short_set, fifo_full, pop, drop;
  logic                  overrun_q, short_q;
  rx_word_t              push_word, head;

  always_comb begin
    in_recv   = (state_q == StRecv);
    edge_seen = sample_on_rising(mode_q) ? (sclk_s & ~sclk_prev_q) : (~sclk_s & sclk_prev_q);
    sel_rise  = in_recv & sel_s;
    sample    = in_recv & ~sel_s & edge_seen;
    word_done = sample & (bit_cnt_q == CntW'(DATA_WIDTH - 1));
    if (MSB_FIRST != 0) shift_next = {shift_q[DATA_WIDTH-2:0], data_s};
    else                shift_next = {data_s, shift_q[DATA_WIDTH-1:1]};
    // The held word leaves when its successor completes or when the frame closes.
    push_valid = hold_valid_q & (sel_rise | word_done);
    push_word  = '0;
    push_word.data[DATA_WIDTH-1:0] = hold_q;
    push_word.first = hold_first_q;
    push_word.last  = sel_rise;
    short_set = sel_rise & (bit_cnt_q != '0);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q         <= StIdle;
      mode_q          <= MODE0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      hold_q          <= '0;
      hold_valid_q    <= 1'b0;
      hold_first_q    <= 1'b0;
      first_pending_q <= 1'b0;
      armed_q         <= 1'b0;
    end else begin
      armed_q <= armed_q | (sel_s & sync_ok);
      unique case (state_q)
        StIdle: begin
          if (armed_q && !sel_s) begin
            state_q         <= StRecv;
            mode_q          <= spi_mode_t'(mode_in);
            bit_cnt_q       <= '0;
            first_pending_q <= 1'b1;
            hold_valid_q    <= 1'b0;
          end
        end
        StRecv: begin
          if (sel_s) begin
            state_q      <= StIdle;
            hold_valid_q <= 1'b0;
          end else if (sample) begin
            shift_q <= shift_next;
            if (word_done) begin
              bit_cnt_q       <= '0;
              hold_q          <= shift_next;
              hold_valid_q    <= 1'b1;
              hold_first_q    <= first_pending_q;
              first_pending_q <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pop  = m_valid_out & m_ready_in;
  assign drop = push_valid & fifo_full & ~pop;

  spi_rx_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .wr_valid_i (push_valid),
    .wr_data_i  (push_word),
    .full_o     (fifo_full),
    .rd_data_o  (head),
    .rd_valid_o (m_valid_out),
    .rd_ready_i (m_ready_in),
    .count_o    (fifo_count_out)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overrun_q <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      overrun_q <= (overrun_q & ~err_clr_in) | drop;
      short_q   <= (short_q & ~err_clr_in) | short_set;
    end
  end

  logic unused_head_data;
  assign unused_head_data = ^head.data;

  assign m_data_out      = head.data[DATA_WIDTH-1:0];
  assign m_first_out     = head.first;
  assign m_last_out      = head.last;
  assign overrun_out     = overrun_q;
  assign short_frame_out = short_q;

endmodule

// File: tb/tb_spi_rx_framed.sv
// Directed bench for spi_rx_framed: an MSB-first and an LSB-first instance share the pins.
`timescale 1ns / 1ps
module tb_spi_rx_framed;

  localparam int H = 60;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst, data, sclk, sel, err_clr, ready;
  logic [1:0] mode;
  logic       cpol, cpha;

  logic [7:0] m_data, lsb_data;
  logic       m_first, m_last, m_valid, overrun, short_f;
  logic       lsb_first, lsb_last, lsb_valid, lsb_overrun, lsb_short;
  logic [2:0] count, lsb_count;

  int   checks = 0;
  int   errors = 0;
  obs_t rx_q[$];
  obs_t lsb_q[$];

  always #5 clk = ~clk;

  spi_rx_framed #(
    .DATA_WIDTH (8), .FIFO_DEPTH (4), .MSB_FIRST (1), .SYNC_STAGES (2)
  ) dut (
    .clk_in (clk), .rst_in (rst), .data_in (data), .data_clk_in (sclk), .sel_in (sel),
    .mode_in (mode), .err_clr_in (err_clr), .m_data_out (m_data), .m_first_out (m_first),
    .m_last_out (m_last), .m_valid_out (m_valid), .m_ready_in (ready),
    .fifo_count_out (count), .overrun_out (overrun), .short_frame_out (short_f)
  );

  spi_rx_framed #(
    .DATA_WIDTH (8), .FIFO_DEPTH (4), .MSB_FIRST (0), .SYNC_STAGES (2)
  ) dut_lsb (
    .clk_in (clk), .rst_in (rst), .data_in (data), .data_clk_in (sclk), .sel_in (sel),
    .mode_in (mode), .err_clr_in (err_clr), .m_data_out (lsb_data),
    .m_first_out (lsb_first), .m_last_out (lsb_last), .m_valid_out (lsb_valid),
    .m_ready_in (1'b1), .fifo_count_out (lsb_count), .overrun_out (lsb_overrun),
    .short_frame_out (lsb_short)
  );

  always @(negedge clk) begin
    if (m_valid && ready) rx_q.push_back({m_data, m_first, m_last});
    if (lsb_valid) lsb_q.push_back({lsb_data, lsb_first, lsb_last});
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] bitrev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    cpol = m[1];
    cpha = m[0];
    sclk = cpol;
    #(4*H);
  endtask

  // Data changes only on the non-sampling edge of each mode.
  task automatic spi_bit(input logic b);
    if (!cpha) begin
      data = b; #(H); sclk = ~cpol; #(H); sclk = cpol;
    end else begin
      sclk = ~cpol; data = b; #(H); sclk = cpol; #(H);
    end
  endtask

  task automatic spi_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) spi_bit(v[i]);
  endtask

  task automatic sel_low();
    sel = 1'b0; #(H);
  endtask

  task automatic sel_high();
    #(H); sel = 1'b1; #(4*H);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 200 && rx_q.size() < n; i++) @(posedge clk);
    #2;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b1; sclk = 1'b0; data = 1'b0; mode = 2'b00;
    cpol = 1'b0; cpha = 1'b0; err_clr = 1'b0; ready = 1'b1;
    #23;
    checks++;
    if (m_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL reset_held: valid=%b count=%0d, expected 0/0", m_valid, count);
    end
    rst = 1'b0;
    #40;
    checks++;
    if ({m_data, m_first, m_last, m_valid} !== 11'd0) begin
      errors++;
      $display("FAIL reset_head: data=%h first=%b last=%b valid=%b, expected all 0",
               m_data, m_first, m_last, m_valid);
    end
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d, expected 0", count);
    end
    checks++;
    if (overrun !== 1'b0 || short_f !== 1'b0) begin
      errors++; $display("FAIL reset_flags: overrun=%b short=%b, expected 0/0", overrun, short_f);
    end
  endtask

  task automatic test_mode0();
    obs_t exp [2];
    obs_t got;
    exp[0] = {8'hA5, 1'b1, 1'b0};
    exp[1] = {8'h3C, 1'b0, 1'b1};
    set_mode(2'b00);
    rx_q.delete(); lsb_q.delete();
    sel_low(); spi_byte(8'hA5); spi_byte(8'h3C); sel_high();
    wait_rx(2);
    checks++;
    if (rx_q.size() != 2) begin
      errors++; $display("FAIL mode0_words: got %0d words, expected 2", rx_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : '0;
      checks++;
      if (got !== exp[i]) begin
        errors++; $display("FAIL mode0_word%0d: got %h, expected %h", i, got, exp[i]);
      end
    end
    checks++;
    if (overrun !== 1'b0 || short_f !== 1'b0) begin
      errors++; $display("FAIL mode0_flags: overrun=%b short=%b, expected 0/0", overrun, short_f);
    end
  endtask

  task automatic test_modes();
    obs_t exp_m [2];
    obs_t exp_l [2];
    obs_t got;
    exp_m[0] = {8'h81, 1'b1, 1'b0};
    exp_m[1] = {8'h12, 1'b0, 1'b1};
    exp_l[0] = {bitrev(8'h81), 1'b1, 1'b0};
    exp_l[1] = {bitrev(8'h12), 1'b0, 1'b1};
    for (int m = 1; m < 4; m++) begin
      set_mode(2'(m));
      rx_q.delete(); lsb_q.delete();
      sel_low(); spi_byte(8'h81); spi_byte(8'h12); sel_high();
      wait_rx(2);
      for (int i = 0; i < 2; i++) begin
        got = (i < rx_q.size()) ? rx_q[i] : '0;
        checks++;
        if (got !== exp_m[i]) begin
          errors++; $display("FAIL mode%0d_msb_word%0d: got %h, expected %h", m, i, got, exp_m[i]);
        end
        got = (i < lsb_q.size()) ? lsb_q[i] : '0;
        checks++;
        if (got !== exp_l[i]) begin
          errors++; $display("FAIL mode%0d_lsb_word%0d: got %h, expected %h", m, i, got, exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_short_frame();
    obs_t got;
    set_mode(2'b00);
    rx_q.delete();
    sel_low(); spi_byte(8'h7E);
    for (int i = 0; i < 3; i++) spi_bit(1'b0);
    sel_high();
    wait_rx(1);
    got = (rx_q.size() > 0) ? rx_q[0] : '0;
    checks++;
    if (rx_q.size() != 1 || got !== {8'h7E, 1'b1, 1'b1}) begin
      errors++; $display("FAIL short_word: got %h (n=%0d), expected 1fb", got, rx_q.size());
    end
    checks++;
    if (short_f !== 1'b1) begin
      errors++; $display("FAIL short_set: got %b, expected 1", short_f);
    end
    pulse_clr();
    checks++;
    if (short_f !== 1'b0) begin
      errors++; $display("FAIL short_clear: got %b, expected 0", short_f);
    end
  endtask

  task automatic test_overrun();
    obs_t got, exp;
    set_mode(2'b00);
    ready = 1'b0;
    rx_q.delete();
    sel_low();
    for (int b = 0; b < 6; b++) spi_byte(8'(b));
    sel_high();
    checks++;
    if (count !== 3'd4 || m_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_count: count=%0d valid=%b, expected 4/1", count, m_valid);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_flag: got %b, expected 1", overrun);
    end
    checks++;
    if (m_data !== 8'h00 || m_first !== 1'b1) begin
      errors++; $display("FAIL ovr_head: data=%h first=%b, expected 00/1", m_data, m_first);
    end
    @(posedge clk); #1 ready = 1'b1;
    wait_rx(4);
    for (int i = 0; i < 4; i++) begin
      exp = {8'(i), (i == 0), 1'b0};
      got = (i < rx_q.size()) ? rx_q[i] : '0;
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL ovr_drain%0d: got %h, expected %h", i, got, exp);
      end
    end
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL ovr_empty: count=%0d, expected 0", count);
    end
    pulse_clr();
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: got %b, expected 0", overrun);
    end
  endtask

  task automatic test_reset_midframe_release();
    obs_t got;
    set_mode(2'b00);
    rx_q.delete();
    rst = 1'b1;
    sel_low();
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) spi_bit(i[0]);
    sel_high();
    sel_low(); spi_byte(8'h55); sel_high();
    wait_rx(1);
    got = (rx_q.size() > 0) ? rx_q[0] : '0;
    checks++;
    if (got !== {8'h55, 1'b1, 1'b1}) begin
      errors++; $display("FAIL rstrel_word: got %h, expected %h", got, {8'h55, 2'b11});
    end
    checks++;
    if (short_f !== 1'b0) begin
      errors++; $display("FAIL rstrel_short: got %b, expected 0", short_f);
    end
  endtask

  task automatic test_async_reset();
    obs_t got;
    set_mode(2'b00);
    ready = 1'b0;
    rx_q.delete();
    sel_low(); spi_byte(8'h11); spi_byte(8'h22); sel_high();
    checks++;
    if (count !== 3'd2 || m_data !== 8'h11 || m_first !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: count=%0d data=%h first=%b, expected 2/11/1", count, m_data, m_first);
    end
    sel_low();
    for (int i = 0; i < 4; i++) spi_bit(~i[0]);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_data, m_first, m_last, m_valid, count, overrun, short_f} !== 16'd0) begin
      errors++;
      $display("FAIL arst_async: data=%h first=%b last=%b valid=%b count=%0d ovr=%b short=%b",
               m_data, m_first, m_last, m_valid, count, overrun, short_f);
    end
    sel = 1'b1; data = 1'b0;
    #(4*H);
    rst = 1'b0;
    #(4*H);
    @(posedge clk); #1 ready = 1'b1;
    #2;
    sel_low(); spi_byte(8'hC3); sel_high();
    wait_rx(1);
    got = (rx_q.size() > 0) ? rx_q[0] : '0;
    checks++;
    if (rx_q.size() != 1 || got !== {8'hC3, 1'b1, 1'b1}) begin
      errors++; $display("FAIL arst_post: got %h (n=%0d), expected %h", got, rx_q.size(),
                         {8'hC3, 2'b11});
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_short_frame();
    test_overrun();
    test_reset_midframe_release();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
